// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    // addi x0,x0,0: returned in place of data on a faulting fetch
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    function automatic logic word_in_range(input logic [31:0] byte_addr,
                                           input logic [31:0] depth_words);
        return ({2'b00, byte_addr[31:2]} < depth_words);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port and one write port.
// A read in the same edge as a write to that word returns the old contents.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] NOP_INST    = NOP_INST_DEFAULT,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic          rd_nop,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rd_data_r;

    // Program-load write; array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Read register; a faulting fetch loads the NOP instead of array data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= NOP_INST;
        end else if (rd_en) begin
            rd_data_r <= rd_nop ? NOP_INST : mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder for the fetch stage: accepts a
// fetch address, returns instruction/PC/fault after LATENCY cycles, drops work on flush.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] NOP_INST    = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic        flush,
    input  logic        resp_ready,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic [31:0] resp_pc,
    output logic        resp_fault,
    output logic        fetch_stall,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);

    localparam int unsigned   CW       = $clog2(LATENCY + 1);
    localparam int unsigned   AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    imem_state_e   state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   addr_r;
    logic          resp_valid_r;
    logic [31:0]   resp_pc_r;
    logic          resp_fault_r;

    logic          accept_s;
    logic          enter_s;
    logic [31:0]   enter_addr_s;
    logic          fault_s;
    logic          wr_en_s;
    logic          fetch_stall_s;

    // Request acceptance and RESP-entry detection with the address to read
    always_comb begin
        accept_s     = 1'b0;
        enter_s      = 1'b0;
        enter_addr_s = addr_r;
        if (req_valid && !flush &&
            ((state_r == IDLE) || ((state_r == RESP) && resp_ready))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        // With single-cycle latency the accepting edge is also the read edge
        if (accept_s && (LATENCY == 32'd1)) begin
            enter_s      = 1'b1;
            enter_addr_s = req_addr;
        end else if (!flush && (state_r == WAIT) && (cnt_r == CNT_ONE)) begin
            enter_s      = 1'b1;
            enter_addr_s = addr_r;
        end else begin
            enter_s      = 1'b0;
            enter_addr_s = addr_r;
        end
    end

    assign fault_s = (enter_addr_s[1:0] != 2'b00) ||
                     !word_in_range(enter_addr_s, 32'(DEPTH_WORDS));
    assign wr_en_s = prog_we && word_in_range(prog_addr, 32'(DEPTH_WORDS));

    // IF hold request; forced low while reset is asserted
    always_comb begin
        fetch_stall_s = 1'b0;
        if (!rst) begin
            fetch_stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    fetch_stall_s = req_valid && !flush;
                WAIT:    fetch_stall_s = 1'b1;
                RESP:    fetch_stall_s = !(resp_ready && !flush);
                default: fetch_stall_s = 1'b0;
            endcase
        end
    end

    // Control FSM, latency counter and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            addr_r       <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_pc_r    <= 32'h0000_0000;
            resp_fault_r <= 1'b0;
        end else if (flush) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        addr_r <= req_addr;
                        if (LATENCY == 32'd1) begin
                            state_r <= RESP;
                        end else begin
                            cnt_r   <= CNT_LOAD;
                            state_r <= WAIT;
                        end
                    end else if ((state_r == RESP) && resp_ready) begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_ONE) begin
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: state_r <= IDLE;
            endcase
            if (enter_s) begin
                resp_valid_r <= 1'b1;
                resp_pc_r    <= enter_addr_s;
                resp_fault_r <= fault_s;
            end else if ((state_r == RESP) && resp_ready) begin
                resp_valid_r <= 1'b0;
            end
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .NOP_INST    (NOP_INST),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (enter_s),
        .rd_nop  (fault_s),
        .rd_idx  (enter_addr_s[AW+1:2]),
        .rd_data (resp_inst),
        .wr_en   (wr_en_s),
        .wr_idx  (prog_addr[AW+1:2]),
        .wr_data (prog_wdata)
    );

    assign resp_valid  = resp_valid_r;
    assign resp_pc     = resp_pc_r;
    assign resp_fault  = resp_fault_r;
    assign fetch_stall = fetch_stall_s;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY=2 and LATENCY=1 instances, table-driven
// fetches plus hand sequences, responses checked against a scoreboard queue.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        fault;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;

    logic        d2_req_valid, d2_flush, d2_resp_ready;
    logic [31:0] d2_req_addr;
    logic        d2_resp_valid, d2_resp_fault, d2_fetch_stall;
    logic [31:0] d2_resp_inst, d2_resp_pc;

    logic        d1_req_valid, d1_flush, d1_resp_ready;
    logic [31:0] d1_req_addr;
    logic        d1_resp_valid, d1_resp_fault, d1_fetch_stall;
    logic [31:0] d1_resp_inst, d1_resp_pc;

    exp_t        sb2_q[$];
    exp_t        sb1_q[$];
    logic [31:0] model [DEPTH];
    vec_t        vecs [9];
    int          n_cmp = 0;
    int          n_bad = 0;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .NOP_INST(NOP)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(d2_req_valid), .req_addr(d2_req_addr),
        .flush(d2_flush), .resp_ready(d2_resp_ready), .resp_valid(d2_resp_valid),
        .resp_inst(d2_resp_inst), .resp_pc(d2_resp_pc), .resp_fault(d2_resp_fault),
        .fetch_stall(d2_fetch_stall), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata)
    );

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .NOP_INST(NOP)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(d1_req_valid), .req_addr(d1_req_addr),
        .flush(d1_flush), .resp_ready(d1_resp_ready), .resp_valid(d1_resp_valid),
        .resp_inst(d1_resp_inst), .resp_pc(d1_resp_pc), .resp_fault(d1_resp_fault),
        .fetch_stall(d1_fetch_stall), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0011);
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a, input logic f);
        exp_t e;
        e.pc    = a;
        e.fault = f;
        e.inst  = f ? NOP : model[a[11:2]];
        return e;
    endfunction

    // Scoreboard for the LATENCY=2 instance: a handshake pops one expectation
    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst && d2_resp_valid && d2_resp_ready && !d2_flush) begin
            if (sb2_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d2_unexpected: response pc %08h with nothing expected", d2_resp_pc);
            end else begin
                e = sb2_q.pop_front();
                chk("d2_pc", d2_resp_pc, e.pc);
                chk("d2_inst", d2_resp_inst, e.inst);
                chk1("d2_fault", d2_resp_fault, e.fault);
            end
        end
    end

    // Scoreboard for the LATENCY=1 instance
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst && d1_resp_valid && d1_resp_ready && !d1_flush) begin
            if (sb1_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d1_unexpected: response pc %08h with nothing expected", d1_resp_pc);
            end else begin
                e = sb1_q.pop_front();
                chk("d1_pc", d1_resp_pc, e.pc);
                chk("d1_inst", d1_resp_inst, e.inst);
                chk1("d1_fault", d1_resp_fault, e.fault);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat;
        vecs[0] = '{32'h0000_0000, 1'b0, 2};
        vecs[1] = '{32'h0000_0008, 1'b0, 2};
        vecs[2] = '{32'h0000_0100, 1'b0, 2};
        vecs[3] = '{32'h0000_0FFC, 1'b0, 2};
        vecs[4] = '{32'h0000_0002, 1'b1, 2};
        vecs[5] = '{32'h0000_0001, 1'b1, 2};
        vecs[6] = '{32'h0000_1000, 1'b1, 2};
        vecs[7] = '{32'hFFFF_FFFC, 1'b1, 2};
        vecs[8] = '{32'h0000_01FC, 1'b0, 2};

        rst = 1'b0;
        prog_we = 1'b0; prog_addr = 32'h0; prog_wdata = 32'h0;
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0040; d2_flush = 1'b0; d2_resp_ready = 1'b1;
        d1_req_valid = 1'b1; d1_req_addr = 32'h0000_0000; d1_flush = 1'b0; d1_resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_valid", d2_resp_valid, 1'b0);
        chk("rst_inst", d2_resp_inst, NOP);
        chk("rst_pc", d2_resp_pc, 32'h0);
        chk1("rst_fault", d2_resp_fault, 1'b0);
        chk1("rst_stall", d2_fetch_stall, 1'b0);
        chk1("rst_d1_valid", d1_resp_valid, 1'b0);
        chk1("rst_d1_stall", d1_fetch_stall, 1'b0);
        d2_req_valid = 1'b0;
        d1_req_valid = 1'b0;
        step();
        rst = 1'b1;

        // Preload, plus a masked-low-bits write and an out-of-range write
        for (int i = 0; i < 128; i++) begin
            step();
            prog_we = 1'b1; prog_addr = 32'(i) * 32'd4; prog_wdata = pat(i);
            model[i] = pat(i);
        end
        step(); prog_addr = 32'h0000_0FFC; prog_wdata = 32'h7E57_0FFC; model[1023] = 32'h7E57_0FFC;
        step(); prog_addr = 32'h0000_000B; prog_wdata = 32'h1234_5678; model[2] = 32'h1234_5678;
        step(); prog_addr = 32'h0000_1000; prog_wdata = 32'hDEAD_BEEF;
        step(); prog_we = 1'b0;

        // Table-driven single fetches with latency measurement
        for (int i = 0; i < 9; i++) begin
            step();
            d2_req_valid = 1'b1; d2_req_addr = vecs[i].addr;
            sb2_q.push_back(mk_exp(vecs[i].addr, vecs[i].fault));
            settle();
            chk1("idle_accept_stall", d2_fetch_stall, 1'b1);
            step();
            d2_req_valid = 1'b0;
            lat = 1;
            while (d2_resp_valid !== 1'b1 && lat < 8) begin
                step();
                lat++;
            end
            chk("fetch_latency", 32'(lat), 32'(vecs[i].lat));
        end

        // Back-to-back 0x0, 0x4, 0x8 with resp_ready held high
        step();
        d2_req_valid = 1'b1; d2_req_addr = 32'h0;
        sb2_q.push_back(mk_exp(32'h0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("b2b_wait_valid", d2_resp_valid, 1'b0);
            chk1("b2b_wait_stall", d2_fetch_stall, 1'b1);
            step();
            if (k < 2) begin
                d2_req_addr = 32'(k + 1) * 32'd4;
                sb2_q.push_back(mk_exp(d2_req_addr, 1'b0));
            end else begin
                d2_req_valid = 1'b0;
            end
            settle();
            chk1("b2b_resp_valid", d2_resp_valid, 1'b1);
            chk1("b2b_resp_stall", d2_fetch_stall, 1'b0);
        end

        // Backpressure: hold for 3 cycles, then handshake with a same-cycle request
        step();
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0010;
        sb2_q.push_back(mk_exp(32'h0000_0010, 1'b0));
        step();
        d2_req_valid = 1'b0; d2_resp_ready = 1'b0;
        step();
        for (int j = 0; j < 3; j++) begin
            settle();
            chk1("bp_valid", d2_resp_valid, 1'b1);
            chk("bp_pc", d2_resp_pc, 32'h0000_0010);
            chk("bp_inst", d2_resp_inst, model[4]);
            chk1("bp_stall", d2_fetch_stall, 1'b1);
            step();
        end
        d2_resp_ready = 1'b1; d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0014;
        sb2_q.push_back(mk_exp(32'h0000_0014, 1'b0));
        settle();
        chk1("bp_release_stall", d2_fetch_stall, 1'b0);
        step();
        d2_req_valid = 1'b0;
        settle();
        chk1("bp_next_accepted_valid", d2_resp_valid, 1'b0);
        chk1("bp_next_accepted_stall", d2_fetch_stall, 1'b1);
        step();
        chk1("bp_next_resp_valid", d2_resp_valid, 1'b1);

        // Flush during WAIT kills the access; then a fresh fetch of 0x100
        step();
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0020;
        step();
        d2_req_valid = 1'b0; d2_flush = 1'b1;
        step();
        d2_flush = 1'b0;
        chk1("flush_wait_valid0", d2_resp_valid, 1'b0);
        step();
        chk1("flush_wait_valid1", d2_resp_valid, 1'b0);
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0100;
        sb2_q.push_back(mk_exp(32'h0000_0100, 1'b0));
        step();
        d2_req_valid = 1'b0;
        step();
        chk1("post_flush_valid", d2_resp_valid, 1'b1);
        chk("post_flush_pc", d2_resp_pc, 32'h0000_0100);

        // Flush in IDLE with a request: request is ignored
        step();
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0044; d2_flush = 1'b1;
        settle();
        chk1("flush_idle_stall", d2_fetch_stall, 1'b0);
        step();
        d2_req_valid = 1'b0; d2_flush = 1'b0;
        step();
        chk1("flush_idle_valid0", d2_resp_valid, 1'b0);
        step();
        chk1("flush_idle_valid1", d2_resp_valid, 1'b0);

        // Flush in RESP together with resp_ready: flush wins
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0048;
        step();
        d2_req_valid = 1'b0;
        step();
        chk1("flush_resp_valid", d2_resp_valid, 1'b1);
        chk("flush_resp_pc", d2_resp_pc, 32'h0000_0048);
        d2_flush = 1'b1;
        settle();
        chk1("flush_resp_stall", d2_fetch_stall, 1'b1);
        step();
        d2_flush = 1'b0;
        chk1("flush_resp_after", d2_resp_valid, 1'b0);

        // Reset in the middle of an access: no response afterwards
        step();
        d2_req_valid = 1'b1; d2_req_addr = 32'h0000_0030;
        step();
        d2_req_valid = 1'b0; rst = 1'b0;
        settle();
        chk1("midrst_valid", d2_resp_valid, 1'b0);
        chk1("midrst_stall", d2_fetch_stall, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk1("midrst_after0", d2_resp_valid, 1'b0);
        step();
        chk1("midrst_after1", d2_resp_valid, 1'b0);

        // LATENCY=1: back-to-back 0x0, 0x4 with a write to 0x4 on its read edge
        step();
        d1_req_valid = 1'b1; d1_req_addr = 32'h0;
        sb1_q.push_back(mk_exp(32'h0, 1'b0));
        step();
        d1_req_addr = 32'h0000_0004;
        sb1_q.push_back(mk_exp(32'h0000_0004, 1'b0));
        prog_we = 1'b1; prog_addr = 32'h0000_0004; prog_wdata = 32'hCAFE_F00D;
        settle();
        chk1("l1_valid0", d1_resp_valid, 1'b1);
        chk1("l1_stall0", d1_fetch_stall, 1'b0);
        step();
        prog_we = 1'b0; model[1] = 32'hCAFE_F00D; d1_req_valid = 1'b0;
        settle();
        chk1("l1_valid1", d1_resp_valid, 1'b1);
        chk1("l1_stall1", d1_fetch_stall, 1'b0);
        chk("l1_pc1", d1_resp_pc, 32'h0000_0004);
        step();
        chk1("l1_idle_valid", d1_resp_valid, 1'b0);
        d1_req_valid = 1'b1; d1_req_addr = 32'h0000_0004;
        sb1_q.push_back(mk_exp(32'h0000_0004, 1'b0));
        step();
        d1_req_valid = 1'b0;
        chk1("l1_refetch_valid", d1_resp_valid, 1'b1);
        repeat (3) step();

        chk("sb2_drained", 32'(sb2_q.size()), 32'd0);
        chk("sb1_drained", 32'(sb1_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder on the far end of the fetch interface. It accepts a fetch address from the IF stage, models a fixed-latency instruction memory, and returns the instruction word together with its PC to the IF/ID boundary. It drives the stall back to IF while an access is outstanding, and it discards in-flight accesses on a control-flow redirect. A program-load write port fills the array before or during simulation.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array.
- LATENCY, 2: cycles from request acceptance to response valid. Must be ≥ 1.
- NOP_INST, 32'h0000_0013: word returned on a fault (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset. Single clock domain; asynchronous assert, active-low (0 = reset).
- req_valid  in  1  IF presents a fetch address this cycle.
- req_addr  in  32  fetch byte address (F_PC).
- flush  in  1  redirect taken (next_pc_sel). Kills any outstanding access.
- resp_ready  in  1  ID can take the response (ID not stalled).
- resp_valid  out  1  resp_inst, resp_pc and resp_fault are valid.
- resp_inst  out  32  fetched instruction.
- resp_pc  out  32  address of resp_inst.
- resp_fault  out  1  misaligned or out-of-range fetch.
- fetch_stall  out  1  IF must hold its PC this cycle.
- prog_we  in  1  program-load write enable.
- prog_addr  in  32  program-load byte address; bits [1:0] are ignored.
- prog_wdata  in  32  program-load data.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** on req_valid && !flush:
  - latch req_addr;
  - if LATENCY == 1, go to RESP;
  - otherwise load the counter with LATENCY-1 and go to WAIT.
- **WAIT:** decrement the counter each cycle. When it reaches 1, go to RESP.
- **Entry into RESP:** read the array at the latched word index and register the result into resp_inst/resp_pc/resp_fault. resp_valid is 1 while in RESP.
- **RESP:** hold all outputs stable until resp_ready.
  - On resp_valid && resp_ready with req_valid && !flush, accept the new request in the same cycle (back-to-back), using the same entry rule as IDLE.
  - On resp_valid && resp_ready without a new request, go to IDLE.
- **Fault:** req_addr[1:0] != 0 or word index ≥ DEPTH_WORDS sets resp_fault=1 and resp_inst=NOP_INST. A faulting fetch still takes the full LATENCY.
- **flush:** in any state, go to IDLE on the next edge. resp_valid is 0 from that edge on. A req_valid in the flush cycle is ignored; IF re-presents the redirected PC on the next cycle.
- **fetch_stall** = (state != IDLE) && !(state == RESP && resp_ready && !flush). fetch_stall is also high in IDLE when req_valid && !flush, because the request was accepted and IF must hold the PC.
- **prog_we:** writes prog_wdata to word prog_addr[31:2], masked to range. Out-of-range writes are dropped. A write to the word being read on the RESP-entry edge returns the old data.

## Timing
- **Reset values:** state=IDLE, resp_valid=0, resp_inst=NOP_INST, resp_pc=0, resp_fault=0, fetch_stall=0. Array contents are not reset.
- **Reset mid-access:** the access is abandoned and no response is produced after release.
- **Latency:** request accepted at edge T → resp_valid high after edge T+LATENCY.
- **Throughput:** one instruction per LATENCY cycles with resp_ready held high.
- **Counter width:** $clog2(LATENCY+1). No wrap is possible.
- **flush and resp_ready both high in RESP:** flush wins; the response is still considered consumed by ID only if ID ignores it (ID also flushes).

## Structure
- imem_pkg holds the state enum (IDLE/WAIT/RESP) and the NOP_INST default constant.
- Sub-module imem_array is the storage: one synchronous read port and one write port, parameterised by DEPTH_WORDS.
- imem_responder holds the FSM, counter, fault check and output registers.

## Test plan
- **Reset/idle:** rst=0 with req_valid=1 → all outputs at reset values. Release → first fetch of 0x0 gives resp_valid after 2 edges, resp_pc=0, and resp_inst equals the preloaded word.
- **Back-to-back:** resp_ready=1, addresses 0x0, 0x4, 0x8 → responses in order, every 2 cycles, fetch_stall high exactly in the WAIT cycles and low in the RESP cycles.
- **Backpressure:** resp_ready=0 for 3 cycles in RESP → resp_inst/resp_pc held, fetch_stall=1. resp_ready=1 → handshake completes and the next request is accepted in that same cycle.
- **Flush in WAIT:** flush at cycle T+1 → no response for that address. The next request to 0x100 returns the word at 0x100 with resp_pc=0x100.
- **Faults:** req_addr=0x2 → resp_fault=1, resp_inst=32'h13. Address 4*DEPTH_WORDS → resp_fault=1. Both faults take 2 cycles.
- **LATENCY=1 build:** 0x0, 0x4 back-to-back → resp_valid continuous and fetch_stall never high with resp_ready=1. A prog_we to 0x4 in the RESP-entry cycle returns the old word.
